// File: rtl/apu_reg_loader.sv
// apu_reg_loader: host-link byte stream to APU register file.
// Accepts address/data byte pairs, holds 32 eight-bit registers, and
// toggles a per-channel change bit on writes to each channel's last register.
// Optional feature macro: APU_REG_READBACK_EN (registered read port).
module apu_reg_loader #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
`ifdef APU_REG_READBACK_EN
  input  logic [4:0]   rd_addr,
  output logic [7:0]   rd_data,
`endif
  output logic [255:0] apu_reg,
  output logic [7:0]   reg_change,
  output logic         wr_pulse,
  output logic         err
);

  typedef enum logic {
    S_ADDR,
    S_DATA
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      addr_q, addr_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [255:0]    apu_reg_q, apu_reg_d;
  logic [7:0]      reg_change_q, reg_change_d;
  logic            wr_pulse_q, wr_pulse_d;
  logic            err_q, err_d;

  // FSM control strobes
  logic            addr_ld;
  logic            cnt_clr;
  logic            cnt_inc;
  logic            wr_en;
  logic            err_set;
  logic            to_hit;

  assign to_hit = (cnt_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an arriving data byte takes priority over timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ADDR: begin
        if (rx_valid && rx_data[7]) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid || to_hit) begin
          state_d = S_ADDR;
        end
      end
      default: state_d = S_ADDR;
    endcase
  end

  // Output/control decode per state
  always_comb begin
    addr_ld = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    wr_en   = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      S_ADDR: begin
        if (rx_valid) begin
          if (rx_data[7]) begin
            addr_ld = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          wr_en = 1'b1;
        end else if (to_hit) begin
          err_set = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath next-state: address latch, timeout counter, register file, flags
  always_comb begin
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    apu_reg_d    = apu_reg_q;
    reg_change_d = reg_change_q;
    wr_pulse_d   = wr_en;
    err_d        = err_q | err_set;

    if (addr_ld) begin
      addr_d = rx_data[4:0];
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_inc) begin
      cnt_d = cnt_q + TW'(1);
    end

    if (wr_en) begin
      apu_reg_d[{addr_q, 3'b000} +: 8] = rx_data;
      if (addr_q[1:0] == 2'd3) begin
        reg_change_d[addr_q[4:2]] = ~reg_change_q[addr_q[4:2]];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      apu_reg_q    <= '0;
      reg_change_q <= '0;
      wr_pulse_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      apu_reg_q    <= apu_reg_d;
      reg_change_q <= reg_change_d;
      wr_pulse_q   <= wr_pulse_d;
      err_q        <= err_d;
    end
  end

  assign apu_reg    = apu_reg_q;
  assign reg_change = reg_change_q;
  assign wr_pulse   = wr_pulse_q;
  assign err        = err_q;

`ifdef APU_REG_READBACK_EN
  logic [7:0] rd_data_q;

  // Registered readback; reads the pre-write value on a same-cycle collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= apu_reg_q[{rd_addr, 3'b000} +: 8];
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_apu_reg_loader.sv
// Testbench for apu_reg_loader: directed test-plan sequences plus random
// byte traffic, compared every cycle against a pair-level reference model.
module tb_apu_reg_loader;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = '0;
  logic [255:0] apu_reg;
  logic [7:0]   reg_change;
  logic         wr_pulse;
  logic         err;
`ifdef APU_REG_READBACK_EN
  logic [4:0]   rd_addr = '0;
  logic [7:0]   rd_data;
`endif

  apu_reg_loader #(.TIMEOUT(TO), .TW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
`ifdef APU_REG_READBACK_EN
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
`endif
    .apu_reg    (apu_reg),
    .reg_change (reg_change),
    .wr_pulse   (wr_pulse),
    .err        (err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: pending pair plus count of idle cycles since the address
  logic [7:0] m_reg [32];
  bit         m_pend;
  int         m_addr;
  int         m_wait;
  logic [7:0] m_chg;
  bit         m_wr;
  bit         m_err;
  logic [7:0] m_rd;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [255:0] m_flat();
    logic [255:0] f;
    for (int i = 0; i < 32; i++) f[8*i +: 8] = m_reg[i];
    return f;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pend = 0; m_addr = 0; m_wait = 0;
    m_chg = '0; m_wr = 0; m_err = 0; m_rd = '0;
  endtask

  task automatic m_step(input bit v, input logic [7:0] d, input logic [4:0] ra);
    m_rd = m_reg[ra];
    m_wr = 0;
    if (m_pend) begin
      if (v) begin
        m_reg[m_addr] = d;
        m_wr = 1;
        if (m_addr % 4 == 3) m_chg[m_addr / 4] = ~m_chg[m_addr / 4];
        m_pend = 0;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_err = 1;
          m_pend = 0;
        end
      end
    end else if (v) begin
      if (d[7]) begin
        m_pend = 1;
        m_addr = int'(d[4:0]);
        m_wait = 0;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("apu_reg", apu_reg, m_flat());
    chk("reg_change", 256'(reg_change), 256'(m_chg));
    chk("wr_pulse", 256'(wr_pulse), 256'(m_wr));
    chk("err", 256'(err), 256'(m_err));
`ifdef APU_REG_READBACK_EN
    chk("rd_data", 256'(rd_data), 256'(m_rd));
`endif
  endtask

  // One clock: drive inputs, model the edge, check just after it
  task automatic cyc(input bit v, input logic [7:0] d);
    logic [4:0] ra;
    ra = 5'($urandom_range(0, 31));
    rx_valid = v;
    rx_data  = d;
`ifdef APU_REG_READBACK_EN
    rd_addr = ra;
`endif
    @(posedge clk);
    m_step(v, d, ra);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b1, a);
    cyc(1'b1, d);
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge
  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n = 1'b0;
    m_reset();
    #2;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    #3;
    do_reset();
    chk("reset_reg", apu_reg, '0);
    chk("reset_chg", 256'(reg_change), 256'(8'h00));

    // Basic write
    pair(8'h80, 8'hBF);
    chk("basic_reg0", 256'(apu_reg[7:0]), 256'(8'hBF));
    chk("basic_pulse", 256'(wr_pulse), 256'(1'b1));
    chk("basic_chg", 256'(reg_change), 256'(8'h00));
    idle(1);
    chk("basic_pulse_off", 256'(wr_pulse), 256'(1'b0));

    // Channel toggles
    pair(8'h83, 8'h08);
    chk("tog_reg3", 256'(apu_reg[31:24]), 256'(8'h08));
    chk("tog_chg_set", 256'(reg_change), 256'(8'h01));
    pair(8'h83, 8'h08);
    chk("tog_chg_clr", 256'(reg_change), 256'(8'h00));
    pair(8'h87, 8'h00);
    chk("tog_chg1", 256'(reg_change), 256'(8'h02));

    // Protocol error then a good pair
    cyc(1'b1, 8'h12);
    chk("perr_err", 256'(err), 256'(1'b1));
    pair(8'h85, 8'h55);
    chk("perr_reg5", 256'(apu_reg[47:40]), 256'(8'h55));

    // Timeout: 16 idle clocks abandon the pair
    do_reset();
    cyc(1'b1, 8'h81);
    idle(TO);
    chk("to_err", 256'(err), 256'(1'b1));
    chk("to_reg1", 256'(apu_reg[15:8]), 256'(8'h00));

    // Data on the last allowed clock is accepted
    do_reset();
    cyc(1'b1, 8'h81);
    idle(TO - 1);
    cyc(1'b1, 8'h5A);
    chk("to_edge_reg1", 256'(apu_reg[15:8]), 256'(8'h5A));
    chk("to_edge_err", 256'(err), 256'(1'b0));

    // One clock late: byte lands in address phase
    do_reset();
    cyc(1'b1, 8'h81);
    idle(TO);
    cyc(1'b1, 8'h33);
    chk("to_late_reg1", 256'(apu_reg[15:8]), 256'(8'h00));

    // Mid-pair reset drops the pending address
    do_reset();
    cyc(1'b1, 8'h9F);
    do_reset();
    cyc(1'b1, 8'h44);
    chk("midrst_err", 256'(err), 256'(1'b1));
    chk("midrst_reg31", 256'(apu_reg[255:248]), 256'(8'h00));

    // Random traffic in segments of varying density
    do_reset();
    for (int s = 0; s < 60; s++) begin
      int unsigned pct;
      pct = (s % 3 == 0) ? 8 : ((s % 3 == 1) ? 50 : 95);
      if ($urandom_range(0, 9) == 0) do_reset();
      for (int i = 0; i < 50; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if ($urandom_range(0, 3) != 0) b[7] = m_pend ? b[7] : 1'b1;
        cyc($urandom_range(0, 99) < pct, b);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apu_reg_loader.md
# apu_reg_loader

Upstream register-file stage of the APU. It receives a byte stream from the host link as address/data pairs and holds the 32 eight-bit APU registers. It drives the register bytes and per-channel change toggles consumed by the `rectangle`, `triangle` and other channel blocks. Runs in the 894,720 Hz APU clock domain alongside `frame_counter`.

## Interface

Parameters:
- `TIMEOUT`, 1024: clocks allowed between an address byte and its data byte before the pair is abandoned.
- `TW`, 11: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- `clk` in 1: APU clock; every register updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset. Release is synchronous to `clk` upstream.
- `rx_valid` in 1: single-cycle strobe; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `apu_reg` out 256: flattened register file; register n is `apu_reg[8n+7:8n]`.
- `reg_change` out 8: bit g toggles on every write to register 4g+3.
- `wr_pulse` out 1: one-cycle pulse on every committed write.
- `err` out 1: sticky protocol-error flag; cleared only by reset.

## Operation

- State machine has two states: `S_ADDR` and `S_DATA`. Reset state is `S_ADDR`.
- `S_ADDR`, `rx_valid` with `rx_data[7]=1`:
  - latch `addr <= rx_data[4:0]`;
  - clear the timeout counter;
  - go to `S_DATA`.
  - `rx_data[6:5]` are ignored.
- `S_ADDR`, `rx_valid` with `rx_data[7]=0`:
  - discard the byte;
  - set `err`;
  - stay in `S_ADDR`.
- `S_DATA`, `rx_valid`:
  - write `reg[addr] <= rx_data`; any value is legal, including bit 7 set;
  - pulse `wr_pulse`;
  - if `addr[1:0]==3`, toggle `reg_change[addr[4:2]]`;
  - return to `S_ADDR`.
- `S_DATA`, no byte: the timeout counter increments each clock. When it reaches `TIMEOUT-1` without a byte:
  - set `err`;
  - return to `S_ADDR`;
  - nothing is written.
- Simultaneous events: a byte arriving in the same cycle the counter reaches `TIMEOUT-1` is accepted as data. The byte wins.
- Rewriting a register with its current value is still a write: `wr_pulse` fires and `reg_change` toggles if applicable.
- Reset asserted mid-pair:
  - state returns to `S_ADDR` and the pending address is dropped;
  - all 32 registers, `reg_change`, `wr_pulse` and `err` go to 0.

## Timing

- Reset values: `apu_reg`=0, `reg_change`=8'h00, `wr_pulse`=0, `err`=0, state `S_ADDR`, timeout counter 0.
- Latency: data byte strobed in cycle t → `apu_reg`, `reg_change` and `wr_pulse` updated at the clock edge ending cycle t, visible in cycle t+1.
- `wr_pulse` is high for exactly one clock per write.
- Back-to-back bytes on consecutive clocks are supported. The maximum write rate is one write per 2 clocks.
- All outputs are registered; no combinational path from `rx_*` to any output.
- Consumers detect changes by XOR of the current `reg_change` bit against a delayed copy. The toggle is held until the next qualifying write.

## Configuration

- `APU_REG_READBACK_EN` defined:
  - adds input `rd_addr` [4:0] and output `rd_data` [7:0];
  - `rd_data <= reg[rd_addr]` is registered, 1-clock latency, reset value 0;
  - a write and a read to the same address in the same cycle returns the old value.
- Undefined: those ports and their logic are absent. All other behaviour is identical.

## Test plan

- Reset check: assert `rst_n`=0 → all 256 `apu_reg` bits 0, `reg_change`=0, `err`=0.
- Basic write: bytes 0x80, 0xBF → register 0 = 0xBF one cycle after the data strobe; `wr_pulse` high one clock; `reg_change` unchanged.
- Channel toggle: bytes 0x83, 0x08 → register 3 = 0x08 and `reg_change[0]` 0→1. Repeating the pair returns `reg_change[0]` to 0. Bytes 0x87, 0x00 → `reg_change[1]` toggles.
- Protocol error: byte 0x12 in `S_ADDR` → no write, `err`=1. A subsequent 0x85, 0x55 still writes register 5 = 0x55.
- Timeout with `TIMEOUT`=16: byte 0x81, then no bytes for 16 clocks → `err`=1 and register 1 unchanged. A data byte on exactly clock 15 after the address is written to register 1.
- Mid-pair reset: 0x9F, then pulse `rst_n` low, then 0x44 → 0x44 is treated as an address byte with bit 7 clear, `err`=1, and register 31 stays 0.
